// File: rtl/imem_boot_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// The FSM states, frame-length width and instruction word width live here.
package imem_boot_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_e;

  // The frame length arrives low byte first.
  function automatic logic [LEN_W-1:0] len_join(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, IMEM write port and core-control bundle for the boot loader.
// The slave modport is the loader; the master modport is the receiver/memory side.
import imem_boot_loader_pkg::*;

interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;

  modport master (
    output rx_data, rx_valid, start,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error
  );

  modport slave (
    input  rx_data, rx_valid, start,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_hold, done, error
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Collects four bytes, first byte in bits 7:0, and presents the assembled word
// with a one-cycle word_valid pulse in the cycle after the fourth byte.
import imem_boot_loader_pkg::*;

module byte_word_assembler (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [1:0]        byte_cnt_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      // Shift right so the first byte of the word ends up in the low lane.
      shift_d = {byte_i, shift_q[WORD_W-1:8]};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_valid_o = valid_q;
  assign word_o       = shift_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed byte frame and writes words to IMEM while
// holding the core in reset. Optional trailing XOR checksum via BOOT_CHECKSUM_EN.
//
// state  | meaning
// LEN_LO | waiting for low byte of word count
// LEN_HI | waiting for high byte of word count, length check
// DATA   | collecting data bytes, one IMEM write per four bytes
// CSUM   | waiting for trailing XOR byte (BOOT_CHECKSUM_EN only)
// DONE   | program loaded, core released
// ERROR  | frame rejected, core held
import imem_boot_loader_pkg::*;

module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input logic                clk_i,
  input logic                rst_ni,
  imem_boot_loader_if.slave  bus_if
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              all_in_q, all_in_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              rx_ready;
  logic              fire;
  logic              restart;
  logic              asm_byte_valid;
  logic [1:0]        asm_byte_cnt;
  logic              asm_word_valid;
  logic [WORD_W-1:0] asm_word;
  logic [LEN_W-1:0]  len;

  always_comb begin
    case (state_q)
      LEN_LO, LEN_HI, DATA, CSUM: rx_ready = 1'b1;
      default:                    rx_ready = 1'b0;
    endcase
  end

  assign fire    = bus_if.rx_valid && rx_ready;
  assign restart = bus_if.start && ((state_q == DONE) || (state_q == ERROR));
  assign len     = len_join(len_lo_q, bus_if.rx_data);
  // Once the last word's bytes are in, any byte seen during its write cycle is
  // not data: it is the checksum byte, or dropped when checksums are off.
  assign asm_byte_valid = fire && (state_q == DATA) && !all_in_q;

  byte_word_assembler u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (restart),
    .byte_valid_i(asm_byte_valid),
    .byte_i      (bus_if.rx_data),
    .byte_cnt_o  (asm_byte_cnt),
    .word_valid_o(asm_word_valid),
    .word_o      (asm_word)
  );

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    all_in_d   = all_in_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = fire ? (csum_q ^ bus_if.rx_data) : csum_q;
`endif
    case (state_q)
      LEN_LO: begin
        if (fire) begin
          len_lo_d = bus_if.rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (fire) begin
          last_idx_d = ADDR_W'(len - LEN_W'(1));
          if (len == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else if ({16'd0, len} > 32'(MAX_WORDS)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_byte_valid && (asm_byte_cnt == 2'd3) && (idx_q == last_idx_q)) begin
          all_in_d = 1'b1;
        end
        if (asm_word_valid) begin
          if (idx_q == last_idx_q) begin
            all_in_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            if (fire) begin
              state_d = (bus_if.rx_data == csum_q) ? DONE : ERROR;
            end else begin
              state_d = CSUM;
            end
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: begin
        if (fire) begin
          state_d = (bus_if.rx_data == csum_q) ? DONE : ERROR;
        end
      end
`endif
      DONE, ERROR: begin
        if (restart) begin
          state_d  = LEN_LO;
          idx_d    = '0;
          all_in_d = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LEN_LO;
      len_lo_q   <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      all_in_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      all_in_q   <= all_in_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus_if.rx_ready   = rx_ready;
  assign bus_if.imem_we    = asm_word_valid;
  assign bus_if.imem_addr  = idx_q;
  assign bus_if.imem_wdata = asm_word;
  assign bus_if.core_hold  = (state_q != DONE);
  assign bus_if.done       = (state_q == DONE);
  assign bus_if.error      = (state_q == ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; expected IMEM writes are queued as frames
// are driven and popped by a monitor on each write pulse.
import imem_boot_loader_pkg::*;

module tb_imem_boot_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  logic [7:0] exp_addr;
  logic [7:0] csum;

  imem_boot_loader_if #(.ADDR_W(8)) bif ();

  imem_boot_loader #(
    .ADDR_W   (8),
    .MAX_WORDS(256)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_if(bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the oldest queued write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (bif.imem_we === 1'b1) begin
        check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("write_addr", {24'd0, bif.imem_addr}, {24'd0, w.addr});
          check("write_data", bif.imem_wdata, w.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    while (bif.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", {31'd0, bif.rx_ready}, 32'd1);
    csum = csum ^ b;
    @(negedge clk);
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    exp_addr = '0;
    csum     = '0;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    exp_q.push_back('{addr: exp_addr, data: w});
    exp_addr++;
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        @(negedge clk);
        check("rx_ready_idle", {31'd0, bif.rx_ready}, 32'd1);
      end
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic end_frame();
`ifdef BOOT_CHECKSUM_EN
    send_byte(csum);
`else
    @(negedge clk);
`endif
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    check("restart_hold", {31'd0, bif.core_hold}, 32'd1);
    check("restart_done", {31'd0, bif.done}, 32'd0);
    check("restart_error", {31'd0, bif.error}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, bif.rx_ready}, 32'd1);
    check({tag, "_we"}, {31'd0, bif.imem_we}, 32'd0);
    check({tag, "_addr"}, {24'd0, bif.imem_addr}, 32'd0);
    check({tag, "_wdata"}, bif.imem_wdata, 32'd0);
    check({tag, "_hold"}, {31'd0, bif.core_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, bif.done}, 32'd0);
    check({tag, "_error"}, {31'd0, bif.error}, 32'd0);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, {31'd0, bif.done}, 32'd1);
    check({tag, "_hold"}, {31'd0, bif.core_hold}, 32'd0);
    check({tag, "_error"}, {31'd0, bif.error}, 32'd0);
  endtask

  initial begin
    bif.rx_data  = '0;
    bif.rx_valid = 1'b0;
    bif.start    = 1'b0;
    exp_addr     = '0;
    csum         = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // N=2 back-to-back
    send_len(16'd2);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0050_0093, 1'b0);
    check("n2_we_latency", {31'd0, bif.imem_we}, 32'd1);
    check("n2_hold_during_write", {31'd0, bif.core_hold}, 32'd1);
    end_frame();
    check_done("n2");

    // Same frame with rx_valid toggling
    pulse_start();
    send_len(16'd2);
    send_word(32'h0000_0013, 1'b1);
    send_word(32'h0050_0093, 1'b1);
    check("tog_we_latency", {31'd0, bif.imem_we}, 32'd1);
    end_frame();
    check_done("tog");

    // N=0 then N=300
    pulse_start();
    send_len(16'd0);
    check("n0_no_we", {31'd0, bif.imem_we}, 32'd0);
    end_frame();
    check_done("n0");
    pulse_start();
    send_len(16'd300);
    check("n300_error", {31'd0, bif.error}, 32'd1);
    check("n300_hold", {31'd0, bif.core_hold}, 32'd1);
    check("n300_rx_ready", {31'd0, bif.rx_ready}, 32'd0);
    check("n300_done", {31'd0, bif.done}, 32'd0);

    // Reset after six data bytes of an N=2 load
    pulse_start();
    send_len(16'd2);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h93);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_rst_pending", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_we", {31'd0, bif.imem_we}, 32'd0);
    send_len(16'd1);
    send_word(32'hCAFE_0A37, 1'b0);
    check("n1_we_latency", {31'd0, bif.imem_we}, 32'd1);
    end_frame();
    check_done("n1");

    // start ignored mid-DATA, honoured in DONE
    pulse_start();
    send_len(16'd2);
    exp_q.push_back('{addr: 8'd0, data: 32'h1122_3344});
    exp_addr = 8'd1;
    send_byte(8'h44);
    send_byte(8'h33);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    check("mid_start_done", {31'd0, bif.done}, 32'd0);
    check("mid_start_hold", {31'd0, bif.core_hold}, 32'd1);
    check("mid_start_rx_ready", {31'd0, bif.rx_ready}, 32'd1);
    send_byte(8'h22);
    send_byte(8'h11);
    send_word(32'hAABB_CCDD, 1'b0);
    check("mid_start_we", {31'd0, bif.imem_we}, 32'd1);
    end_frame();
    check_done("mid_start");
    pulse_start();
    send_len(16'd1);
    send_word(32'h0000_0013, 1'b0);
    end_frame();
    check_done("reload");

`ifdef BOOT_CHECKSUM_EN
    pulse_start();
    send_len(16'd1);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h12);
    check_done("csum_ok");
    pulse_start();
    send_len(16'd1);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h00);
    check("csum_bad_error", {31'd0, bif.error}, 32'd1);
    check("csum_bad_hold", {31'd0, bif.core_hold}, 32'd1);
`endif

    repeat (2) @(negedge clk);
    check("writes_outstanding", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
